// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM tone generator: the FSM state encoding and
// the processor register map.
package pwm_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      REST = 2'd2
   } state_t;

   localparam logic [1:0] ADDR_PERIOD = 2'd0;
   localparam logic [1:0] ADDR_DUTY   = 2'd1;
   localparam logic [1:0] ADDR_CTRL   = 2'd2;

endpackage

// File: rtl/pwm_tone_gen_sync2.sv
// Two-flop synchronizer for one asynchronous level input.
// Both stages clear on the synchronous active-high reset.
module sync2 (
   input  logic clock,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   // Shift the input through two flops to settle metastability.
   always_ff @(posedge clock) begin
      if (reset) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pwm_tone_gen.sv
// PWM tone generator: register bank with pending/live PERIOD and DUTY,
// IDLE/RUN/REST FSM, period counter and registered PWM output.
// Build option: define PWM_INPUT_SYNC_EN to pass rest/active through
// 2-flop synchronizers (2 extra cycles of latency); otherwise they feed the
// next-state logic directly.
module pwm_tone_gen
   import pwm_pkg::*;
#(
   parameter int CNT_W = 20
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        wr_en,
   input  logic [1:0]  wr_addr,
   input  logic [31:0] wr_data,
   input  logic        rest,
   input  logic        active,
   output logic        pwm_out,
   output logic        period_done,
   output logic [1:0]  state
);

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   logic             rest_s;
   logic             active_s;
   logic [CNT_W-1:0] pend_period, pend_duty;
   logic [CNT_W-1:0] pend_period_nxt, pend_duty_nxt;
   logic [CNT_W-1:0] live_period, live_duty;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] last_cnt;
   logic             at_last;
   logic             en, en_nxt;
   logic             load_live;
   state_t           cur_state, nstate;
   logic             unused_wr_data;

`ifdef PWM_INPUT_SYNC_EN
   sync2 u_sync_rest (
      .clock (clock),
      .reset (reset),
      .d     (rest),
      .q     (rest_s)
   );

   sync2 u_sync_active (
      .clock (clock),
      .reset (reset),
      .d     (active),
      .q     (active_s)
   );
`else
   assign rest_s   = rest;
   assign active_s = active;
`endif

   // Only the low CNT_W bits of a write are meaningful.
   assign unused_wr_data = ^wr_data[31:CNT_W];

   assign last_cnt    = live_period - ONE;
   assign at_last     = (cnt == last_cnt);
   assign period_done = (cur_state == RUN) && at_last;
   assign state       = cur_state;

   // Register-write decode; a fresh write is visible to a same-cycle live copy.
   always_comb begin
      // NOTE: every output gets a default first so no latch is inferred.
      pend_period_nxt = pend_period;
      pend_duty_nxt   = pend_duty;
      en_nxt          = en;
      if (wr_en) begin
         case (wr_addr)
            ADDR_PERIOD: pend_period_nxt = wr_data[CNT_W-1:0];
            ADDR_DUTY:   pend_duty_nxt   = wr_data[CNT_W-1:0];
            ADDR_CTRL:   en_nxt          = wr_data[0];
            default:     ;
         endcase
      end
      // active overrides a same-cycle CTRL clear.
      if (active_s) en_nxt = 1'b1;
   end

   // Next-state logic; rest takes priority over every other transition.
   always_comb begin
      nstate    = cur_state;
      load_live = 1'b0;
      case (cur_state)
         IDLE: begin
            if (en_nxt && !rest_s && (pend_period != '0)) begin
               nstate    = RUN;
               load_live = 1'b1;
            end
         end
         RUN: begin
            if (rest_s) begin
               nstate = REST;
            end else if (at_last) begin
               load_live = 1'b1;
               if (!en_nxt) nstate = IDLE;
            end
         end
         REST: begin
            if (!rest_s) nstate = en_nxt ? RUN : IDLE;
         end
         default: nstate = IDLE;
      endcase
   end

   // State, register bank, counter and PWM output.
   always_ff @(posedge clock) begin
      // NOTE: non-blocking assignments for all sequential state.
      if (reset) begin
         cur_state   <= IDLE;
         pend_period <= '0;
         pend_duty   <= '0;
         live_period <= '0;
         live_duty   <= '0;
         en          <= 1'b0;
         cnt         <= '0;
         pwm_out     <= 1'b0;
      end else begin
         cur_state   <= nstate;
         pend_period <= pend_period_nxt;
         pend_duty   <= pend_duty_nxt;
         en          <= en_nxt;
         if (load_live) begin
            live_period <= pend_period_nxt;
            live_duty   <= pend_duty_nxt;
         end
         // IDLE pins the counter at 0; REST and the REST->RUN edge hold it.
         if (nstate == IDLE) begin
            cnt <= '0;
         end else if ((cur_state == RUN) && (nstate == RUN)) begin
            cnt <= at_last ? '0 : cnt + ONE;
         end
         pwm_out <= (cur_state == RUN) && (cnt < live_duty);
      end
   end

endmodule

// File: tb/tb_pwm_tone_gen.sv
// Directed testbench for pwm_tone_gen (default build, no input synchronizers).
// Inputs change 1 time unit after each rising edge; outputs are sampled there.
module tb_pwm_tone_gen;

   logic        clock;
   logic        reset;
   logic        wr_en;
   logic [1:0]  wr_addr;
   logic [31:0] wr_data;
   logic        rest;
   logic        active;
   logic        pwm_out;
   logic        period_done;
   logic [1:0]  state;

   int n_cmp = 0;
   int n_err = 0;

   // Hand-computed expectations for the longer windows.
   int exp_dty_pwm [6] = '{0, 0, 1, 1, 1, 0};
   int exp_dty_cnt [6] = '{3, 0, 1, 2, 3, 0};
   int exp_pre_pwm [5] = '{1, 1, 0, 1, 1};
   int exp_pre_cnt [5] = '{2, 3, 0, 1, 2};
   int exp_zero_pwm[8] = '{1, 1, 1, 0, 0, 0, 0, 0};

   pwm_tone_gen #(.CNT_W(20)) dut (
      .clock       (clock),
      .reset       (reset),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .rest        (rest),
      .active      (active),
      .pwm_out     (pwm_out),
      .period_done (period_done),
      .state       (state)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wr(input logic [1:0] addr, input logic [31:0] data);
      wr_en   = 1'b1;
      wr_addr = addr;
      wr_data = data;
      tick();
      wr_en   = 1'b0;
   endtask

   initial begin
      reset   = 1'b1;
      wr_en   = 1'b0;
      wr_addr = 2'd0;
      wr_data = 32'd0;
      rest    = 1'b0;
      active  = 1'b0;
      tick();
      tick();
      reset = 1'b0;

      // Reset state
      check("rst_state", 32'(state), 32'd0);
      check("rst_pwm", 32'(pwm_out), 32'd0);
      check("rst_pd", 32'(period_done), 32'd0);
      check("rst_cnt", 32'(dut.cnt), 32'd0);

      // PERIOD=4, DUTY=1, CTRL=1 -> 1,0,0,0 with period_done on cnt=3
      wr(2'd0, 32'd4);
      check("cfg_idle", 32'(state), 32'd0);
      wr(2'd1, 32'd1);
      wr(2'd2, 32'd1);
      check("start_state", 32'(state), 32'd1);
      check("start_cnt", 32'(dut.cnt), 32'd0);
      check("start_pwm", 32'(pwm_out), 32'd0);
      for (int k = 1; k <= 8; k++) begin
         tick();
         check($sformatf("d1_cnt%0d", k), 32'(dut.cnt), 32'(k % 4));
         check($sformatf("d1_pwm%0d", k), 32'(pwm_out), 32'((k % 4) == 1));
         check($sformatf("d1_pd%0d", k), 32'(period_done), 32'((k % 4) == 3));
      end

      // DUTY 1->3 written at cnt=1: current period unchanged, next is 1,1,1,0
      tick();
      check("d3_pre_cnt", 32'(dut.cnt), 32'd1);
      wr(2'd1, 32'd3);
      check("d3_wr_pwm", 32'(pwm_out), 32'd0);
      for (int j = 0; j < 6; j++) begin
         tick();
         check($sformatf("d3_cnt%0d", j), 32'(dut.cnt), 32'(exp_dty_cnt[j]));
         check($sformatf("d3_pwm%0d", j), 32'(pwm_out), 32'(exp_dty_pwm[j]));
      end

      // DUTY=2, then rest for 5 cycles at cnt=2
      wr(2'd1, 32'd2);
      check("d2_wr_pwm", 32'(pwm_out), 32'd1);
      for (int j = 0; j < 5; j++) begin
         tick();
         check($sformatf("d2_cnt%0d", j), 32'(dut.cnt), 32'(exp_pre_cnt[j]));
         check($sformatf("d2_pwm%0d", j), 32'(pwm_out), 32'(exp_pre_pwm[j]));
      end
      rest = 1'b1;
      tick();
      check("rest_state", 32'(state), 32'd2);
      check("rest_cnt", 32'(dut.cnt), 32'd2);
      check("rest_pwm", 32'(pwm_out), 32'd0);
      check("rest_pd", 32'(period_done), 32'd0);
      for (int j = 0; j < 4; j++) tick();
      check("rest_hold_state", 32'(state), 32'd2);
      check("rest_hold_cnt", 32'(dut.cnt), 32'd2);
      check("rest_hold_pwm", 32'(pwm_out), 32'd0);
      rest = 1'b0;
      tick();
      check("resume_state", 32'(state), 32'd1);
      check("resume_cnt", 32'(dut.cnt), 32'd2);
      tick();
      check("resume_cnt3", 32'(dut.cnt), 32'd3);
      check("resume_pd", 32'(period_done), 32'd1);
      tick();
      tick();
      check("resume_cnt1", 32'(dut.cnt), 32'd1);
      check("resume_pwm", 32'(pwm_out), 32'd1);

      // DUTY=7 >= PERIOD -> constant 1; then DUTY=0 -> constant 0 next period
      wr(2'd1, 32'd7);
      tick();
      tick();
      check("d7_sync_cnt", 32'(dut.cnt), 32'd0);
      for (int j = 0; j < 4; j++) begin
         tick();
         check($sformatf("d7_pwm%0d", j), 32'(pwm_out), 32'd1);
      end
      wr(2'd1, 32'd0);
      check("d0_wr_pwm", 32'(pwm_out), 32'd1);
      for (int j = 0; j < 8; j++) begin
         tick();
         check($sformatf("d0_pwm%0d", j), 32'(pwm_out), 32'(exp_zero_pwm[j]));
      end

      // Reset mid-RUN with a CTRL write in the same cycle
      check("pre_rst_state", 32'(state), 32'd1);
      reset   = 1'b1;
      wr_en   = 1'b1;
      wr_addr = 2'd2;
      wr_data = 32'd1;
      tick();
      reset = 1'b0;
      wr_en = 1'b0;
      check("mrst_state", 32'(state), 32'd0);
      check("mrst_pwm", 32'(pwm_out), 32'd0);
      check("mrst_pd", 32'(period_done), 32'd0);
      check("mrst_cnt", 32'(dut.cnt), 32'd0);
      wr(2'd0, 32'd2);
      tick();
      tick();
      check("mrst_ctrl_ignored", 32'(state), 32'd0);

      // PERIOD=0 with active=1 stays IDLE; PERIOD=2 then starts
      wr(2'd0, 32'd0);
      active = 1'b1;
      tick();
      tick();
      tick();
      check("p0_state", 32'(state), 32'd0);
      check("p0_pwm", 32'(pwm_out), 32'd0);
      wr(2'd0, 32'd2);
      check("p2_wr_state", 32'(state), 32'd0);
      tick();
      check("p2_run_state", 32'(state), 32'd1);
      check("p2_run_pd", 32'(period_done), 32'd0);

      // PERIOD=1 -> period_done every RUN cycle once it goes live
      wr(2'd0, 32'd1);
      check("p1_pd0", 32'(period_done), 32'd1);
      tick();
      check("p1_pd1", 32'(period_done), 32'd1);
      check("p1_cnt1", 32'(dut.cnt), 32'd0);
      tick();
      check("p1_pd2", 32'(period_done), 32'd1);

      // active wins over a same-cycle CTRL clear; a later clear stops at boundary
      wr(2'd2, 32'd0);
      check("act_wins", 32'(state), 32'd1);
      active = 1'b0;
      tick();
      check("en_held", 32'(state), 32'd1);
      wr(2'd2, 32'd0);
      check("stop_state", 32'(state), 32'd0);
      check("stop_cnt", 32'(dut.cnt), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
